// File: rtl/mips_stim_seq.sv
// mips_stim_seq: programmable {instruction, read-data} stimulus sequencer for
// the SCPU / pipelined MIPS cores. It plays a loaded table onto inst_in/Data_in,
// one entry per step, and models memory wait states through MIO_ready.
// Optional feature macro: STIM_INT_INJECT_EN adds a one-cycle INT pulse at a
// chosen entry. Without the macro INT is tied low and int_en/int_idx are unused.
module mips_stim_seq #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_inst,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W:0]   len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    input  logic              int_en,
    input  logic [ADDR_W-1:0] int_idx,
    output logic [31:0]       inst_in,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              INT,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYC);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    // Stimulus table; deliberately not cleared by reset so a program survives it.
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        wait_q, wait_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       data_q, data_d;
    logic              mio_q, mio_d;
    logic              int_q, int_d;

    // go: a start accepted this edge; cap: an entry is captured this edge.
    logic              go;
    logic              cap;
    logic [ADDR_W-1:0] cap_idx;
    logic              last_entry;

    // Table write port; any state, one entry per cycle.
    always_ff @(posedge clk) begin
        if (load_we) begin
            inst_mem[load_addr] <= load_inst;
            data_mem[load_addr] <= load_data;
        end
    end

    assign last_entry = ({1'b0, idx_q} == (len_q - 1'b1));

    // Next-state and registered-output computation for the playback FSM.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        loop_d  = loop_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        inst_d  = inst_q;
        data_d  = data_q;
        mio_d   = mio_q;
        go      = 1'b0;
        cap     = 1'b0;
        cap_idx = '0;

        if (stop) begin
            // Abort wins over everything, including a simultaneous start.
            state_d = S_IDLE;
            idx_d   = '0;
            wait_d  = '0;
            inst_d  = '0;
            data_d  = '0;
            mio_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        go     = 1'b1;
                        len_d  = (len > DEPTH_L) ? DEPTH_L : len;
                        loop_d = loop;
                        if (len == '0) begin
                            // Empty program: straight to DONE, nothing presented.
                            state_d = S_DONE;
                            idx_d   = '0;
                            wait_d  = '0;
                            inst_d  = '0;
                            data_d  = '0;
                            mio_d   = 1'b0;
                        end else begin
                            state_d = S_RUN;
                            cap     = 1'b1;
                            cap_idx = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (wait_q != WAIT_L) begin
                        // Still holding the current entry; ready only on the last hold cycle.
                        wait_d = wait_q + 4'd1;
                        mio_d  = ((wait_q + 4'd1) == WAIT_L);
                    end else if (last_entry) begin
                        if (loop_q) begin
                            cap     = 1'b1;
                            cap_idx = '0;
                        end else begin
                            state_d = S_DONE;
                            idx_d   = '0;
                            wait_d  = '0;
                            inst_d  = '0;
                            data_d  = '0;
                            mio_d   = 1'b0;
                        end
                    end else begin
                        cap     = 1'b1;
                        cap_idx = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    wait_d  = '0;
                    inst_d  = '0;
                    data_d  = '0;
                    mio_d   = 1'b0;
                end
            endcase
        end

        // Capture reads the table before this edge's write lands, so a
        // same-edge write to the captured index presents the old contents.
        if (cap) begin
            idx_d  = cap_idx;
            wait_d = '0;
            inst_d = inst_mem[cap_idx];
            data_d = data_mem[cap_idx];
            mio_d  = (WAIT_L == 4'd0);
        end
    end

`ifdef STIM_INT_INJECT_EN
    logic              int_en_q;
    logic [ADDR_W-1:0] int_idx_q;
    logic              int_en_eff;
    logic [ADDR_W-1:0] int_idx_eff;

    // Interrupt fires on the capture (first hold cycle) of the chosen entry.
    always_comb begin
        int_en_eff  = go ? int_en  : int_en_q;
        int_idx_eff = go ? int_idx : int_idx_q;
        int_d       = cap && int_en_eff && (cap_idx == int_idx_eff)
                      && ({1'b0, int_idx_eff} < len_d);
    end

    // Interrupt configuration is latched together with the start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_en_q  <= 1'b0;
            int_idx_q <= '0;
        end else if (go && !stop) begin
            int_en_q  <= int_en;
            int_idx_q <= int_idx;
        end
    end
`else
    logic unused_int;

    assign int_d      = 1'b0;
    assign unused_int = ^{int_en, int_idx};
`endif

    // State and output registers; reset clears every visible output at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            loop_q  <= 1'b0;
            idx_q   <= '0;
            wait_q  <= '0;
            inst_q  <= '0;
            data_q  <= '0;
            mio_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
            mio_q   <= mio_d;
            int_q   <= int_d;
        end
    end

    assign inst_in   = inst_q;
    assign Data_in   = data_q;
    assign MIO_ready = mio_q;
    assign INT       = int_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign idx       = idx_q;

endmodule
